multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
Main control state machine of the multicycle CPU, directly upstream of the register file.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives RegWrite/RegDst/MemtoReg for the register file, plus the PC, IR, memory and ALU-mux controls.
- Stalls memory-access states on a ready handshake.

Parameters:
OPCODE_WIDTH, 6, width of instruction opcode field
STATE_WIDTH, 4, width of state register encoding

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
opcode  input  OPCODE_WIDTH  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero
IorD  output  1  memory address: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  regfile write data: 0=ALUOut, 1=MDR
PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
RegWrite  output  1  regfile write enable
RegDst  output  1  regfile write address: 0=rt, 1=rd
illegal_op  output  1  one-cycle pulse on unsupported opcode
state  output  STATE_WIDTH  current state (debug)

Behaviour:
- Moore machine: registered state; outputs are pure decode of state, except the mem_ready gating below. Unlisted outputs are 0.
- Reset: if rst=1 at a clk edge, state<=FETCH.
  - While rst=1, all enables are forced to 0 combinationally: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite.
  - Reset mid-instruction aborts it; no partial writeback.
  - The state output reads FETCH from the first edge with rst high.
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- States and transitions:
  - FETCH: MemRead=1, ALUSrcB=01, IorD=0. IRWrite and PCWrite are asserted only while mem_ready=1. Holds until mem_ready=1, then goes to DECODE.
  - DECODE: ALUSrcB=11. Next state by opcode:
    - LW/SW/ADDI -> MEM_ADDR
    - RTYPE -> EXECUTE
    - BEQ -> BRANCH
    - J -> JUMP
    - other -> FETCH, with illegal_op=1 this cycle
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10. Next: LW -> MEM_READ, SW -> MEM_WRITE, ADDI -> ADDI_WB.
  - MEM_READ: MemRead=1, IorD=1. Holds until mem_ready, then MEM_WB.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1. Holds until mem_ready, then FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RTYPE_WB.
  - RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH.
  - JUMP: PCWrite=1, PCSource=10. Next FETCH.
- Latency with mem_ready tied 1 (cycles, fetch to next fetch):
  - LW 5; SW 4; RTYPE 4; ADDI 4; BEQ 3; J 3; illegal 2.
  - Each wait cycle adds one cycle.
- RegWrite is asserted exactly one cycle per register-writing instruction, never in FETCH or DECODE.
- MEM_WRITE holds MemWrite for every stall cycle. Memory must treat the write as committed only on the mem_ready cycle.
- Unused state encodings decode as FETCH outputs with enables 0, and go to FETCH next cycle.
- opcode is sampled only in DECODE and MEM_ADDR; changes elsewhere are ignored.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants
  - state encodings (localparams, STATE_WIDTH bits)
  - ALUOp, ALUSrcB and PCSource encodings
- Sub-module multicycle_ctrl_decode: combinational state-to-control decode, including the rst/mem_ready gating.
- The top module holds the state register and next-state logic.

Test Plan:
- rst=1 for 2 cycles mid-EXECUTE -> state=FETCH; PCWrite=IRWrite=RegWrite=MemWrite=0 during reset; first FETCH after reset asserts MemRead=1.
- opcode=000000, mem_ready=1 -> states FETCH, DECODE, EXECUTE, RTYPE_WB; RegWrite=1, RegDst=1 only in cycle 4; back to FETCH in cycle 5.
- opcode=100011, mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles with MemRead=1, IorD=1; one MEM_WB cycle with RegWrite=1, MemtoReg=1.
- opcode=101011, mem_ready=1 -> 4 cycles; MemWrite=1 in cycle 4 only; RegWrite never asserted.
- opcode=000100, then opcode=000010 -> BRANCH: PCWriteCond=1, ALUOp=01, PCSource=01. JUMP: PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- opcode=111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; no enables asserted except the FETCH set; FETCH with mem_ready=0 for 2 cycles keeps IRWrite=PCWrite=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Shared constants for the multicycle CPU control path: opcodes,
//            state encodings and ALU / mux select encodings.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int c_opcode_width = 6;
    localparam int c_state_width  = 4;

    // Supported instruction opcodes (IR[31:26])
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    // Controller state encodings; 11..15 are unused and recover to FETCH
    localparam logic [3:0] c_st_fetch     = 4'd0;
    localparam logic [3:0] c_st_decode    = 4'd1;
    localparam logic [3:0] c_st_mem_addr  = 4'd2;
    localparam logic [3:0] c_st_mem_read  = 4'd3;
    localparam logic [3:0] c_st_mem_wb    = 4'd4;
    localparam logic [3:0] c_st_mem_write = 4'd5;
    localparam logic [3:0] c_st_execute   = 4'd6;
    localparam logic [3:0] c_st_rtype_wb  = 4'd7;
    localparam logic [3:0] c_st_addi_wb   = 4'd8;
    localparam logic [3:0] c_st_branch    = 4'd9;
    localparam logic [3:0] c_st_jump      = 4'd10;

    // ALU operation select
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] c_srcb_reg     = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_decode
// Brief    : Combinational state-to-control decode for the multicycle CPU.
//            Memory handshake gates the fetch-side loads; reset forces every
//            write/request enable low.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = c_opcode_width,
    parameter int STATE_WIDTH  = c_state_width
) (
    input  logic                    i_rst,
    input  logic [STATE_WIDTH-1:0]  i_state,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_mem_ready,
    output logic                    o_pc_write,
    output logic                    o_pc_write_cond,
    output logic                    o_iord,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic                    o_ir_write,
    output logic                    o_mem_to_reg,
    output logic [1:0]              o_pc_source,
    output logic [1:0]              o_alu_op,
    output logic                    o_alu_src_a,
    output logic [1:0]              o_alu_src_b,
    output logic                    o_reg_write,
    output logic                    o_reg_dst,
    output logic                    o_illegal_op
);

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic [1:0] w_pc_source;
    logic [1:0] w_alu_op;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_illegal_op;

    // Per-state control decode followed by reset gating of the enables
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_pc_source     = c_pcsrc_alu;
        w_alu_op        = c_aluop_add;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = c_srcb_reg;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_illegal_op    = 1'b0;

        case (i_state)
            STATE_WIDTH'(c_st_fetch): begin
                w_mem_read  = 1'b1;
                w_alu_src_b = c_srcb_four;
                // IR and PC+4 are only captured on the cycle memory delivers
                w_ir_write  = i_mem_ready;
                w_pc_write  = i_mem_ready;
            end
            STATE_WIDTH'(c_st_decode): begin
                w_alu_src_b = c_srcb_imm_sh2;
                case (i_opcode)
                    OPCODE_WIDTH'(c_op_rtype), OPCODE_WIDTH'(c_op_lw),
                    OPCODE_WIDTH'(c_op_sw),    OPCODE_WIDTH'(c_op_beq),
                    OPCODE_WIDTH'(c_op_j),     OPCODE_WIDTH'(c_op_addi):
                        w_illegal_op = 1'b0;
                    default:
                        w_illegal_op = 1'b1;
                endcase
            end
            STATE_WIDTH'(c_st_mem_addr): begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = c_srcb_imm;
            end
            STATE_WIDTH'(c_st_mem_read): begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            STATE_WIDTH'(c_st_mem_wb): begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            STATE_WIDTH'(c_st_mem_write): begin
                // Held through stalls; memory commits on the mem_ready cycle
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            STATE_WIDTH'(c_st_execute): begin
                w_alu_src_a = 1'b1;
                w_alu_op    = c_aluop_funct;
            end
            STATE_WIDTH'(c_st_rtype_wb): begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            STATE_WIDTH'(c_st_addi_wb): begin
                w_reg_write = 1'b1;
            end
            STATE_WIDTH'(c_st_branch): begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = c_aluop_sub;
                w_pc_write_cond = 1'b1;
                w_pc_source     = c_pcsrc_aluout;
            end
            STATE_WIDTH'(c_st_jump): begin
                w_pc_write  = 1'b1;
                w_pc_source = c_pcsrc_jump;
            end
            default: begin
                // Unused encodings look like FETCH but request nothing
                w_alu_src_b = c_srcb_four;
            end
        endcase

        if (i_rst) begin
            w_pc_write      = 1'b0;
            w_pc_write_cond = 1'b0;
            w_mem_read      = 1'b0;
            w_mem_write     = 1'b0;
            w_ir_write      = 1'b0;
            w_reg_write     = 1'b0;
            w_illegal_op    = 1'b0;
        end
    end

    assign o_pc_write      = w_pc_write;
    assign o_pc_write_cond = w_pc_write_cond;
    assign o_iord          = w_iord;
    assign o_mem_read      = w_mem_read;
    assign o_mem_write     = w_mem_write;
    assign o_ir_write      = w_ir_write;
    assign o_mem_to_reg    = w_mem_to_reg;
    assign o_pc_source     = w_pc_source;
    assign o_alu_op        = w_alu_op;
    assign o_alu_src_a     = w_alu_src_a;
    assign o_alu_src_b     = w_alu_src_b;
    assign o_reg_write     = w_reg_write;
    assign o_reg_dst       = w_reg_dst;
    assign o_illegal_op    = w_illegal_op;

endmodule : multicycle_ctrl_decode
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Brief    : Main control state machine of the multicycle CPU. Holds the
//            state register and next-state logic; control outputs come from
//            the decode sub-module.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = c_opcode_width,
    parameter int STATE_WIDTH  = c_state_width
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    mem_ready,
    output logic                    PCWrite,
    output logic                    PCWriteCond,
    output logic                    IorD,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic                    MemtoReg,
    output logic [1:0]              PCSource,
    output logic [1:0]              ALUOp,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic                    RegWrite,
    output logic                    RegDst,
    output logic                    illegal_op,
    output logic [STATE_WIDTH-1:0]  state
);

    logic [STATE_WIDTH-1:0] r_state;
    logic [STATE_WIDTH-1:0] w_next_state;

    // Next-state selection; opcode is only consulted in DECODE and MEM_ADDR
    always_comb begin
        w_next_state = STATE_WIDTH'(c_st_fetch);
        case (r_state)
            STATE_WIDTH'(c_st_fetch):
                w_next_state = mem_ready ? STATE_WIDTH'(c_st_decode)
                                         : STATE_WIDTH'(c_st_fetch);
            STATE_WIDTH'(c_st_decode): begin
                case (opcode)
                    OPCODE_WIDTH'(c_op_lw), OPCODE_WIDTH'(c_op_sw),
                    OPCODE_WIDTH'(c_op_addi):  w_next_state = STATE_WIDTH'(c_st_mem_addr);
                    OPCODE_WIDTH'(c_op_rtype): w_next_state = STATE_WIDTH'(c_st_execute);
                    OPCODE_WIDTH'(c_op_beq):   w_next_state = STATE_WIDTH'(c_st_branch);
                    OPCODE_WIDTH'(c_op_j):     w_next_state = STATE_WIDTH'(c_st_jump);
                    default:                   w_next_state = STATE_WIDTH'(c_st_fetch);
                endcase
            end
            STATE_WIDTH'(c_st_mem_addr): begin
                case (opcode)
                    OPCODE_WIDTH'(c_op_lw):   w_next_state = STATE_WIDTH'(c_st_mem_read);
                    OPCODE_WIDTH'(c_op_sw):   w_next_state = STATE_WIDTH'(c_st_mem_write);
                    OPCODE_WIDTH'(c_op_addi): w_next_state = STATE_WIDTH'(c_st_addi_wb);
                    default:                  w_next_state = STATE_WIDTH'(c_st_fetch);
                endcase
            end
            STATE_WIDTH'(c_st_mem_read):
                w_next_state = mem_ready ? STATE_WIDTH'(c_st_mem_wb)
                                         : STATE_WIDTH'(c_st_mem_read);
            STATE_WIDTH'(c_st_mem_write):
                w_next_state = mem_ready ? STATE_WIDTH'(c_st_fetch)
                                         : STATE_WIDTH'(c_st_mem_write);
            STATE_WIDTH'(c_st_execute):
                w_next_state = STATE_WIDTH'(c_st_rtype_wb);
            default:
                w_next_state = STATE_WIDTH'(c_st_fetch);
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STATE_WIDTH'(c_st_fetch);
        end else begin
            r_state <= w_next_state;
        end
    end

    assign state = r_state;

    multicycle_ctrl_decode #(
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .STATE_WIDTH  (STATE_WIDTH)
    ) u_decode (
        .i_rst           (rst),
        .i_state         (r_state),
        .i_opcode        (opcode),
        .i_mem_ready     (mem_ready),
        .o_pc_write      (PCWrite),
        .o_pc_write_cond (PCWriteCond),
        .o_iord          (IorD),
        .o_mem_read      (MemRead),
        .o_mem_write     (MemWrite),
        .o_ir_write      (IRWrite),
        .o_mem_to_reg    (MemtoReg),
        .o_pc_source     (PCSource),
        .o_alu_op        (ALUOp),
        .o_alu_src_a     (ALUSrcA),
        .o_alu_src_b     (ALUSrcB),
        .o_reg_write     (RegWrite),
        .o_reg_dst       (RegDst),
        .o_illegal_op    (illegal_op)
    );

endmodule : multicycle_control_fsm
`default_nettype wire
